// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg: shared ALU func codes, HI/LO widths and muldiv state encoding
package alu_muldiv_pkg;
    function automatic int util_math_log2(input int v);
        return $clog2(v);
    endfunction
    localparam int DATA_W = 32;
    localparam int CNT_W = util_math_log2(DATA_W) + 1;
    typedef enum logic [3:0] {
        F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT,
        F_MULU, F_MULS, F_DIVU, F_DIVS,
        F_MTHI, F_MTLO, F_MFHI, F_MFLO
    } alu_func_l;
    // Kept as plain localparams so the hazard unit can decode busy from the raw state.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN = 2'd1;
    localparam logic [1:0] ST_FIX = 2'd2;
    typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, FIX = ST_FIX} muldiv_state_e;
endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/read-back/HI-LO bundle; cancel exists only with ALU_MULDIV_CANCEL_EN
interface alu_muldiv_if;
    import alu_muldiv_pkg::*;
    logic req_valid;
    logic req_ready;
    alu_func_l func;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic div0;
`ifdef ALU_MULDIV_CANCEL_EN
    logic cancel;
    modport master (output req_valid, func, data1, data2, cancel,
                    input req_ready, rd_valid, rd_data, busy, hi, lo, div0);
    modport slave (input req_valid, func, data1, data2, cancel,
                   output req_ready, rd_valid, rd_data, busy, hi, lo, div0);
`else
    modport master (output req_valid, func, data1, data2,
                    input req_ready, rd_valid, rd_data, busy, hi, lo, div0);
    modport slave (input req_valid, func, data1, data2,
                   output req_ready, rd_valid, rd_data, busy, hi, lo, div0);
`endif
endinterface

// File: rtl/alu_muldiv_step.sv
// alu_muldiv_step: one radix-2 shift-add (multiply) or restoring subtract (divide) iteration
module alu_muldiv_step
    import alu_muldiv_pkg::*;
(
    input  logic              i_mul,
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_q,
    input  logic [DATA_W-1:0] i_op,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_q
);
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_shl;
    logic [DATA_W:0] w_diff;
    assign w_sum = {1'b0, i_rem} + (i_q[0] ? {1'b0, i_op} : '0);
    assign w_shl = {i_rem, i_q[DATA_W-1]};
    assign w_diff = w_shl - {1'b0, i_op};
    assign o_rem = i_mul ? w_sum[DATA_W:1] : (w_diff[DATA_W] ? w_shl[DATA_W-1:0] : w_diff[DATA_W-1:0]);
    assign o_q = i_mul ? {w_sum[0], i_q[DATA_W-1:1]} : {i_q[DATA_W-2:0], ~w_diff[DATA_W]};
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit owning HI/LO with Mthi/Mtlo/Mfhi/Mflo access.
// Define ALU_MULDIV_CANCEL_EN to add the cancel input that flushes an in-flight op.
module alu_muldiv
    import alu_muldiv_pkg::*;
(
    input logic i_clk,
    input logic i_rst,
    alu_muldiv_if.slave io_bus
);
    muldiv_state_e r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_rem, r_q, r_op, r_hi, r_lo, r_rd_data;
    logic r_mul, r_s1, r_s2, r_div0, r_rd_valid;
    logic w_accept, w_is_mul, w_is_div, w_sgn, w_start, w_rd, w_cancel, w_last, w_fix_wr, w_div0;
    logic [DATA_W-1:0] w_a1, w_a2, w_step_rem, w_step_q, w_quo, w_rem_s, w_new_hi, w_new_lo;
    logic [2*DATA_W-1:0] w_prod, w_prod_s;

    assign w_accept = io_bus.req_valid && r_state == IDLE;
    assign w_is_mul = io_bus.func == F_MULU || io_bus.func == F_MULS;
    assign w_is_div = io_bus.func == F_DIVU || io_bus.func == F_DIVS;
    assign w_sgn = io_bus.func == F_MULS || io_bus.func == F_DIVS;
    assign w_start = w_accept && (w_is_mul || w_is_div);
    assign w_rd = w_accept && (io_bus.func == F_MFHI || io_bus.func == F_MFLO);
`ifdef ALU_MULDIV_CANCEL_EN
    assign w_cancel = io_bus.cancel && r_state != IDLE;
`else
    assign w_cancel = 1'b0;
`endif
    assign w_last = r_cnt == CNT_W'(DATA_W - 1);
    assign w_fix_wr = r_state == FIX && !w_cancel;
    assign w_a1 = (w_sgn && io_bus.data1[DATA_W-1]) ? -io_bus.data1 : io_bus.data1;
    assign w_a2 = (w_sgn && io_bus.data2[DATA_W-1]) ? -io_bus.data2 : io_bus.data2;

    alu_muldiv_step u_step (
        .i_mul(r_mul),
        .i_rem(r_rem),
        .i_q  (r_q),
        .i_op (r_op),
        .o_rem(w_step_rem),
        .o_q  (w_step_q)
    );

    // With a zero divisor the restoring loop leaves the dividend in r_rem and all ones in r_q,
    // so re-signing the remainder yields the raw data1 that HI must receive.
    assign w_prod = {r_rem, r_q};
    assign w_prod_s = (r_s1 ^ r_s2) ? -w_prod : w_prod;
    assign w_div0 = r_op == '0;
    assign w_quo = (r_s1 ^ r_s2) ? -r_q : r_q;
    assign w_rem_s = r_s1 ? -r_rem : r_rem;
    assign w_new_hi = r_mul ? w_prod_s[2*DATA_W-1:DATA_W] : w_rem_s;
    assign w_new_lo = r_mul ? w_prod_s[DATA_W-1:0] : (w_div0 ? '1 : w_quo);

    always_comb begin
        w_next = r_state;
        if (w_cancel)
            w_next = IDLE;
        else if (r_state == IDLE)
            w_next = w_start ? RUN : IDLE;
        else if (r_state == RUN)
            w_next = w_last ? FIX : RUN;
        else
            w_next = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_q <= '0;
            r_op <= '0;
            r_mul <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_hi <= '0;
            r_lo <= '0;
            r_div0 <= 1'b0;
            r_rd_data <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd;
            r_rd_data <= w_rd ? (io_bus.func == F_MFHI ? r_hi : r_lo) : r_rd_data;
            r_hi <= w_fix_wr ? w_new_hi : (w_accept && io_bus.func == F_MTHI) ? io_bus.data1 : r_hi;
            r_lo <= w_fix_wr ? w_new_lo : (w_accept && io_bus.func == F_MTLO) ? io_bus.data1 : r_lo;
            r_div0 <= (w_fix_wr && !r_mul) ? w_div0 : r_div0;
            if (w_start) begin
                r_mul <= w_is_mul;
                r_s1 <= w_sgn && io_bus.data1[DATA_W-1];
                r_s2 <= w_sgn && io_bus.data2[DATA_W-1];
                r_rem <= '0;
                r_q <= w_is_mul ? w_a2 : w_a1;
                r_op <= w_is_mul ? w_a1 : w_a2;
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_rem <= w_step_rem;
                r_q <= w_step_q;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign io_bus.req_ready = r_state == IDLE;
    assign io_bus.busy = r_state != IDLE;
    assign io_bus.rd_valid = r_rd_valid;
    assign io_bus.rd_data = r_rd_data;
    assign io_bus.hi = r_hi;
    assign io_bus.lo = r_lo;
    assign io_bus.div0 = r_div0;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed and randomized checks of alu_muldiv against an arithmetic HI/LO model
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    typedef struct {
        alu_func_l f;
        logic [31:0] a, b, hi, lo;
        logic d0;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_muldiv_if bus();
    alu_muldiv dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi, m_lo;
    logic m_div0;

    function automatic void model(input alu_func_l f, input logic [31:0] a, input logic [31:0] b);
        longint unsigned pu;
        longint ps;
        int sa, sb;
        case (f)
            F_MULU: begin pu = 64'(a) * 64'(b); {m_hi, m_lo} = pu; end
            F_MULS: begin ps = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = ps; end
            F_DIVU, F_DIVS: begin
                if (b == 0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF; m_div0 = 1'b1;
                end else if (f == F_DIVU) begin
                    m_lo = a / b; m_hi = a % b; m_div0 = 1'b0;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a; m_hi = 0; m_div0 = 1'b0;
                end else begin
                    sa = a; sb = b;
                    m_lo = sa / sb; m_hi = sa % sb; m_div0 = 1'b0;
                end
            end
            F_MTHI: m_hi = a;
            F_MTLO: m_lo = a;
            default: ;
        endcase
    endfunction

    task automatic send(input alu_func_l f, input logic [31:0] a, input logic [31:0] b, output int wait_n);
        bus.req_valid = 1'b1; bus.func = f; bus.data1 = a; bus.data2 = b;
        wait_n = 0;
        while (!bus.req_ready && wait_n < 200) begin
            @(posedge clk); #1; wait_n++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.func = F_ADD; bus.data1 = '0; bus.data2 = '0;
`ifdef ALU_MULDIV_CANCEL_EN
        bus.cancel = 1'b0;
`endif
        #1;
        total++;
        if ({bus.req_ready, bus.busy, bus.rd_valid, bus.div0} !== 4'b1000) begin
            bad++; $display("FAIL reset_flags got=%b want=1000", {bus.req_ready, bus.busy, bus.rd_valid, bus.div0});
        end
        total++;
        if ({bus.hi, bus.lo, bus.rd_data} !== 96'h0) begin
            bad++; $display("FAIL reset_regs got=%h/%h/%h want=0", bus.hi, bus.lo, bus.rd_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        m_hi = 0; m_lo = 0; m_div0 = 0;
    endtask

    task automatic test_directed;
        vec_t v[10];
        int w, n;
        v = '{'{F_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0},
              '{F_MULS, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0},
              '{F_DIVS, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0},
              '{F_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0},
              '{F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1},
              '{F_MULU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1},
              '{F_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0},
              '{F_DIVS, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1},
              '{F_DIVS, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0},
              '{F_MULS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0}};
        foreach (v[i]) begin
            send(v[i].f, v[i].a, v[i].b, w);
            total++;
            if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
                bad++; $display("FAIL dir%0d_busy_cycle1 busy=%b ready=%b want 1/0", i, bus.busy, bus.req_ready);
            end
            wait_idle(n);
            total++;
            if (n !== 33) begin
                bad++; $display("FAIL dir%0d_latency got=%0d want=33", i, n);
            end
            total++;
            if ({bus.hi, bus.lo, bus.div0, bus.req_ready} !== {v[i].hi, v[i].lo, v[i].d0, 1'b1}) begin
                bad++; $display("FAIL dir%0d_result got=%h/%h/%b want=%h/%h/%b", i, bus.hi, bus.lo, bus.div0, v[i].hi, v[i].lo, v[i].d0);
            end
            model(v[i].f, v[i].a, v[i].b);
        end
    endtask

    task automatic test_mf_while_busy;
        int w;
        send(F_MULU, 32'd3, 32'd4, w);
        send(F_MFLO, 32'd0, 32'd0, w);
        model(F_MULU, 32'd3, 32'd4);
        total++;
        if (w !== 33) begin
            bad++; $display("FAIL mflo_stall got=%0d want=33", w);
        end
        total++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, 32'd12}) begin
            bad++; $display("FAIL mflo_after_mul got=%b/%h want=1/0000000c", bus.rd_valid, bus.rd_data);
        end
        @(posedge clk); #1;
        total++;
        if (bus.rd_valid !== 1'b0) begin
            bad++; $display("FAIL rd_valid_pulse got=%b want=0", bus.rd_valid);
        end
    endtask

    task automatic test_mt_mf;
        int w;
        send(F_MTHI, 32'hA5A5_A5A5, 32'd0, w);
        total++;
        if (bus.hi !== 32'hA5A5_A5A5 || bus.rd_valid !== 1'b0) begin
            bad++; $display("FAIL mthi got=%h rv=%b want=a5a5a5a5 rv=0", bus.hi, bus.rd_valid);
        end
        send(F_MFHI, 32'd0, 32'd0, w);
        total++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, 32'hA5A5_A5A5}) begin
            bad++; $display("FAIL mfhi_after_mthi got=%b/%h want=1/a5a5a5a5", bus.rd_valid, bus.rd_data);
        end
        send(F_MTLO, 32'h1234_5678, 32'd0, w);
        send(F_MFLO, 32'd0, 32'd0, w);
        total++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, 32'h1234_5678}) begin
            bad++; $display("FAIL mflo_after_mtlo got=%b/%h want=1/12345678", bus.rd_valid, bus.rd_data);
        end
        send(F_MFHI, 32'd0, 32'd0, w);
        total++;
        if ({bus.rd_valid, bus.rd_data, w} !== {1'b1, 32'hA5A5_A5A5, 32'd0}) begin
            bad++; $display("FAIL back_to_back_mfhi got=%b/%h wait=%0d want=1/a5a5a5a5/0", bus.rd_valid, bus.rd_data, w);
        end
        m_hi = 32'hA5A5_A5A5; m_lo = 32'h1234_5678;
        send(F_ADD, 32'hDEAD_BEEF, 32'h1, w);
        total++;
        if ({bus.rd_valid, bus.busy, bus.hi, bus.lo} !== {2'b00, m_hi, m_lo}) begin
            bad++; $display("FAIL other_func got=%b%b %h/%h want=00 %h/%h", bus.rd_valid, bus.busy, bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_random;
        alu_func_l fl[8];
        alu_func_l f;
        logic [31:0] a, b;
        int w, n;
        fl = '{F_MULU, F_MULS, F_DIVU, F_DIVS, F_MTHI, F_MTLO, F_MFHI, F_MFLO};
        for (int i = 0; i < 40; i++) begin
            f = fl[$urandom_range(0, 7)];
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
            send(f, a, b, w);
            if (f == F_MFHI || f == F_MFLO) begin
                total++;
                if ({bus.rd_valid, bus.rd_data} !== {1'b1, (f == F_MFHI) ? m_hi : m_lo}) begin
                    bad++; $display("FAIL rnd%0d_read got=%b/%h want=1/%h", i, bus.rd_valid, bus.rd_data, (f == F_MFHI) ? m_hi : m_lo);
                end
            end else begin
                wait_idle(n);
                model(f, a, b);
                total++;
                if ({bus.hi, bus.lo, bus.div0} !== {m_hi, m_lo, m_div0}) begin
                    bad++; $display("FAIL rnd%0d_%s a=%h b=%h got=%h/%h/%b want=%h/%h/%b", i, f.name(), a, b, bus.hi, bus.lo, bus.div0, m_hi, m_lo, m_div0);
                end
                if (f != F_MTHI && f != F_MTLO) begin
                    total++;
                    if (n !== 33) begin
                        bad++; $display("FAIL rnd%0d_latency got=%0d want=33", i, n);
                    end
                end
            end
        end
    endtask

`ifdef ALU_MULDIV_CANCEL_EN
    task automatic test_cancel;
        int w;
        send(F_MULU, 32'h1234, 32'h5678, w);
        repeat (9) begin @(posedge clk); #1; end
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        total++;
        if ({bus.req_ready, bus.busy, bus.hi, bus.lo, bus.div0} !== {2'b10, m_hi, m_lo, m_div0}) begin
            bad++; $display("FAIL cancel_run got=%b%b %h/%h/%b want=10 %h/%h/%b", bus.req_ready, bus.busy, bus.hi, bus.lo, bus.div0, m_hi, m_lo, m_div0);
        end
        send(F_DIVU, 32'd77, 32'd0, w);
        repeat (32) begin @(posedge clk); #1; end
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        total++;
        if ({bus.req_ready, bus.hi, bus.lo, bus.div0} !== {1'b1, m_hi, m_lo, m_div0}) begin
            bad++; $display("FAIL cancel_fix got=%b %h/%h/%b want=1 %h/%h/%b", bus.req_ready, bus.hi, bus.lo, bus.div0, m_hi, m_lo, m_div0);
        end
        bus.cancel = 1'b1;
        send(F_MTHI, 32'h0BAD_F00D, 32'd0, w);
        bus.cancel = 1'b0;
        m_hi = 32'h0BAD_F00D;
        total++;
        if (bus.hi !== m_hi) begin
            bad++; $display("FAIL cancel_idle got=%h want=%h", bus.hi, m_hi);
        end
    endtask
`endif

    task automatic test_reset_mid;
        int w;
        send(F_DIVU, 32'd100, 32'd7, w);
        repeat (9) begin @(posedge clk); #1; end
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL mid_busy_before_reset got=%b want=1", bus.busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.req_ready, bus.rd_valid, bus.div0, bus.hi, bus.lo} !== {4'b0100, 64'h0}) begin
            bad++; $display("FAIL mid_reset got=%b%b%b%b %h/%h want=0100 0/0", bus.busy, bus.req_ready, bus.rd_valid, bus.div0, bus.hi, bus.lo);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        m_hi = 0; m_lo = 0; m_div0 = 0;
        send(F_MFLO, 32'd0, 32'd0, w);
        total++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL mflo_after_reset got=%b/%h want=1/0", bus.rd_valid, bus.rd_data);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_mf_while_busy();
        test_mt_mf();
        test_random();
`ifdef ALU_MULDIV_CANCEL_EN
        test_cancel();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
